axilite_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file, the next generation of the fixed two-register axilite_slave. It provides NUM_REGS word registers: the lower NUM_RW are read/write, and the rest are read-only mirrors of fabric status inputs.
- Write address and write data are accepted independently and in any order.
- Byte strobes are honoured.
- SLVERR is returned for out-of-range accesses and for writes to read-only registers.
- It sits between the PS AXI GP port (via interconnect) and PL control/status logic.

---
 rtl/axilite_pkg.sv | 30 +++
 rtl/axilite_wr_collect.sv | 90 +++++++++
 rtl/axilite_regfile.sv | 172 +++++++++++++++++
 tb/tb_axilite_regfile.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// ==========================================================================
// axilite_pkg: response codes and helpers for the AXI4-Lite register file.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Operates at the widest supported bus; callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] data,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_word;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_wr_collect.sv
// ==========================================================================
// axilite_wr_collect: AW/W holding buffers, ready generation, commit strobe.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module axilite_wr_collect #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  input  logic                resp_free,
  output logic                commit,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W/8-1:0] commit_strb
);

  logic                aw_full_q, aw_full_d;
  logic                w_full_q, w_full_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;

  assign commit = aw_full_q & w_full_q & resp_free;

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (awvalid && awready_q) begin
        aw_full_d = 1'b1;
        aw_addr_d = awaddr;
      end
      if (wvalid && wready_q) begin
        w_full_d = 1'b1;
        w_data_d = wdata;
        w_strb_d = wstrb;
      end
    end
    // Ready is the registered image of "buffer will be empty".
    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  assign awready     = awready_q;
  assign wready      = wready_q;
  assign commit_addr = aw_addr_q;
  assign commit_data = w_data_q;
  assign commit_strb = w_strb_q;

endmodule

`default_nettype wire

// File: rtl/axilite_regfile.sv
// ==========================================================================
// axilite_regfile: AXI4-Lite slave with NUM_RW RW registers and RO status.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module axilite_regfile
  import axilite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int NUM_REGS           = 8,
  parameter int NUM_RW             = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // Kept one word wide when every register is RW, so the port never collapses.
  input  logic [((NUM_REGS > NUM_RW) ? (NUM_REGS - NUM_RW) : 1)*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW-1:0]                 wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = addr_lsb(DW);

  logic [NUM_RW*DW-1:0] regs_q, regs_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [NUM_RW-1:0]    pulse_q, pulse_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;

  logic                 wc_commit;
  logic [AW-1:0]        wc_addr;
  logic [DW-1:0]        wc_data;
  logic [DW/8-1:0]      wc_strb;
  logic [31:0]          idx_w, idx_r;
  logic [63:0]          merged;
  logic                 unused_addr_bits;

  axilite_wr_collect #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) u_wr_collect (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .resp_free   (~bvalid_q | S_AXI_BREADY),
    .commit      (wc_commit),
    .commit_addr (wc_addr),
    .commit_data (wc_data),
    .commit_strb (wc_strb)
  );

  assign idx_w = 32'(wc_addr[AW-1:ADDR_LSB]);
  assign idx_r = 32'(S_AXI_ARADDR[AW-1:ADDR_LSB]);
  assign unused_addr_bits = ^{wc_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    regs_d   = regs_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    pulse_d  = '0;
    merged   = '0;
    if (wc_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx_w == 32'(i)) begin
          merged = strb_merge(64'(regs_q[i*DW +: DW]), 64'(wc_data), 8'(wc_strb));
          regs_d[i*DW +: DW] = merged[DW-1:0];
          bresp_d    = RESP_OKAY;
          pulse_d[i] = |wc_strb;
        end
      end
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Reads see regs_q, so a same-edge write commit is not visible yet.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (S_AXI_ARVALID && arready_q) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = '0;
      rresp_d   = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx_r == 32'(i)) begin
          rdata_d = regs_q[i*DW +: DW];
          rresp_d = RESP_OKAY;
        end
      end
      for (int i = 0; i < NUM_REGS - NUM_RW; i++) begin
        if (idx_r == 32'(NUM_RW + i)) begin
          rdata_d = ro_in[i*DW +: DW];
          rresp_d = RESP_OKAY;
        end
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d  = 1'b0;
      arready_d = 1'b1;
    end else if (!arready_q && !rvalid_q) begin
      arready_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q    <= {NUM_RW{RESET_VAL}};
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      regs_q    <= regs_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_axilite_regfile.sv
// ==========================================================================
// tb_axilite_regfile: directed self-checking bench for axilite_regfile.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_axilite_regfile;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [11:0]  araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] ro_in = '0;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axilite_regfile dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ro_in         (ro_in),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [3:0] pulse_b, output logic [3:0] pulse_after,
                          output logic ok);
    logic aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(); n++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    ok = bvalid; resp = bresp; pulse_b = wr_pulse;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    pulse_after = wr_pulse;
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic ok);
    int n;
    n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    ok = rvalid; data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
      $display("FAIL rst_handshake: got %b want %b", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    else pass_cnt++;
    total_cnt++;
    if ({bresp, rresp, rdata, wr_pulse} !== 40'h0)
      $display("FAIL rst_resp_data: got %h want %h", {bresp, rresp, rdata, wr_pulse}, 40'h0);
    else pass_cnt++;
    total_cnt++;
    if (reg_out !== 128'h0)
      $display("FAIL rst_regs: got %h want %h", reg_out, 128'h0);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL rst_ready_up: got %b want %b", {awready, wready, arready}, 3'b111);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [3:0] pb, pa; logic ok; logic [31:0] d;
    do_write(12'h000, 32'h5555_5555, 4'hF, resp, pb, pa, ok);
    total_cnt++;
    if ({ok, resp} !== 3'b1_00) $display("FAIL basic_bresp: got %b want %b", {ok, resp}, 3'b100);
    else pass_cnt++;
    total_cnt++;
    if ({pb, pa} !== 8'b0001_0000) $display("FAIL basic_pulse: got %b want %b", {pb, pa}, 8'b0001_0000);
    else pass_cnt++;
    total_cnt++;
    if (reg_out[31:0] !== 32'h5555_5555) $display("FAIL basic_regout: got %h want %h", reg_out[31:0], 32'h5555_5555);
    else pass_cnt++;
    do_read(12'h000, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'h5555_5555})
      $display("FAIL basic_read: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'h5555_5555});
    else pass_cnt++;
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic ok; logic [31:0] d;
    wdata = 32'hAAAA_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total_cnt++;
    if (wready !== 1'b0) $display("FAIL wfirst_wready_drop: got %b want %b", wready, 1'b0);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({wready, bvalid} !== 2'b00) $display("FAIL wfirst_no_commit: got %b want %b", {wready, bvalid}, 2'b00);
    else pass_cnt++;
    awaddr = 12'h004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL wfirst_commit_early: got %b want %b", bvalid, 1'b0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bvalid, bresp, wr_pulse} !== 7'b1_00_0010)
      $display("FAIL wfirst_commit: got %b want %b", {bvalid, bresp, wr_pulse}, 7'b1_00_0010);
    else pass_cnt++;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    total_cnt++;
    if ({bvalid, wready, awready} !== 3'b011)
      $display("FAIL wfirst_b_done: got %b want %b", {bvalid, wready, awready}, 3'b011);
    else pass_cnt++;
    do_read(12'h004, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'hAAAA_AAAA})
      $display("FAIL wfirst_read: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'hAAAA_AAAA});
    else pass_cnt++;
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] pb, pa; logic ok; logic [31:0] d;
    do_write(12'h004, 32'h1234_5678, 4'b0011, resp, pb, pa, ok);
    total_cnt++;
    if ({ok, resp, pb} !== 7'b1_00_0010) $display("FAIL strb_write: got %b want %b", {ok, resp, pb}, 7'b1_00_0010);
    else pass_cnt++;
    do_read(12'h004, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'hAAAA_5678})
      $display("FAIL strb_read: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'hAAAA_5678});
    else pass_cnt++;
    do_write(12'h000, 32'hFFFF_FFFF, 4'b0000, resp, pb, pa, ok);
    total_cnt++;
    if ({ok, resp, pb} !== 7'b1_00_0000) $display("FAIL strb0_write: got %b want %b", {ok, resp, pb}, 7'b1_00_0000);
    else pass_cnt++;
    total_cnt++;
    if (reg_out[31:0] !== 32'h5555_5555) $display("FAIL strb0_nochange: got %h want %h", reg_out[31:0], 32'h5555_5555);
    else pass_cnt++;
  endtask

  task automatic test_ro_slverr();
    logic [1:0] resp; logic [3:0] pb, pa; logic ok; logic [31:0] d;
    ro_in = {32'h0BAD_BEEF, 64'h0, 32'hCAFE_F00D};
    do_read(12'h010, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'hCAFE_F00D})
      $display("FAIL ro_read0: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'hCAFE_F00D});
    else pass_cnt++;
    do_read(12'h01F, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'h0BAD_BEEF})
      $display("FAIL ro_read_last: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'h0BAD_BEEF});
    else pass_cnt++;
    do_write(12'h010, 32'hDEAD_BEEF, 4'hF, resp, pb, pa, ok);
    total_cnt++;
    if ({ok, resp, pb} !== 7'b1_10_0000) $display("FAIL ro_write_slverr: got %b want %b", {ok, resp, pb}, 7'b1_10_0000);
    else pass_cnt++;
    total_cnt++;
    if (reg_out !== {32'h0, 32'h0, 32'hAAAA_5678, 32'h5555_5555})
      $display("FAIL ro_write_nochange: got %h want %h", reg_out, {32'h0, 32'h0, 32'hAAAA_5678, 32'h5555_5555});
    else pass_cnt++;
    do_read(12'h020, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b10, 32'h0})
      $display("FAIL oor_read: got %h want %h", {ok, resp, d}, {1'b1, 2'b10, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp; logic ok; logic [31:0] d;
    awaddr = 12'h008; wdata = 32'h1111_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    total_cnt++;
    if ({bvalid, bresp, wr_pulse} !== 7'b1_00_0100)
      $display("FAIL stall_first_commit: got %b want %b", {bvalid, bresp, wr_pulse}, 7'b1_00_0100);
    else pass_cnt++;
    awaddr = 12'h00C; wdata = 32'h2222_2222;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if ({bvalid, bresp, awready, wready, wr_pulse} !== 9'b1_00_00_0000)
        $display("FAIL stall_hold[%0d]: got %b want %b", k, {bvalid, bresp, awready, wready, wr_pulse}, 9'b1_00_00_0000);
      else pass_cnt++;
      tick();
    end
    bready = 1'b1;
    tick();
    total_cnt++;
    if ({bvalid, bresp, wr_pulse} !== 7'b1_00_1000)
      $display("FAIL stall_back_to_back: got %b want %b", {bvalid, bresp, wr_pulse}, 7'b1_00_1000);
    else pass_cnt++;
    tick();
    bready = 1'b0;
    total_cnt++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL stall_drain: got %b want %b", {bvalid, awready, wready}, 3'b011);
    else pass_cnt++;
    do_read(12'h008, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'h1111_1111})
      $display("FAIL stall_read8: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'h1111_1111});
    else pass_cnt++;
    do_read(12'h00C, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'h2222_2222})
      $display("FAIL stall_readC: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'h2222_2222});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] pb, pa; logic ok, saw_b; logic [31:0] d;
    awaddr = 12'h008; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total_cnt++;
    if (awready !== 1'b0) $display("FAIL mid_aw_held: got %b want %b", awready, 1'b0);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({awready, wready, bvalid, reg_out} !== {3'b000, 128'h0})
      $display("FAIL mid_async_clear: got %h want %h", {awready, wready, bvalid, reg_out}, {3'b000, 128'h0});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_b = 1'b0;
    repeat (5) begin
      tick();
      saw_b = saw_b | bvalid;
    end
    total_cnt++;
    if ({saw_b, reg_out} !== {1'b0, 128'h0})
      $display("FAIL mid_discarded: got %h want %h", {saw_b, reg_out}, {1'b0, 128'h0});
    else pass_cnt++;
    do_write(12'h008, 32'h0F0F_0F0F, 4'hF, resp, pb, pa, ok);
    total_cnt++;
    if ({ok, resp, pb, pa} !== 11'b1_00_0100_0000)
      $display("FAIL mid_next_write: got %b want %b", {ok, resp, pb, pa}, 11'b1_00_0100_0000);
    else pass_cnt++;
    do_read(12'h008, d, resp, ok);
    total_cnt++;
    if ({ok, resp, d} !== {1'b1, 2'b00, 32'h0F0F_0F0F})
      $display("FAIL mid_read: got %h want %h", {ok, resp, d}, {1'b1, 2'b00, 32'h0F0F_0F0F});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first();
    test_strobe();
    test_ro_slverr();
    test_bready_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
